countdown_timer_module: RTL

Countdown timer for the clock's timer mode. It is the down-counting counterpart of the stopwatch: the user sets an hh:mm:ss value, and the block decrements it once per second, with borrow from minutes and hours, until it reaches 00:00:00. At zero it raises a sticky alarm. It sits beside the stopwatch and clock modes under the top-level mode mux and drives the same sec/min/hr display bus.

---
 rtl/countdown_timer_module_pkg.sv | 31 +++
 rtl/countdown_timer_module_if.sv | 25 ++
 rtl/countdown_timer_module_mod_n_updown_counter.sv | 30 +++
 rtl/countdown_timer_module.sv | 134 +++++++++++++
 4 files changed

// File: rtl/countdown_timer_module_pkg.sv
// Shared definitions for the countdown timer: field ranges, FSM states,
// edit-field encoding and the field-cycling helper.
package timer_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  typedef enum logic [1:0] {
    FIELD_SEC = 2'd0,
    FIELD_MIN = 2'd1,
    FIELD_HR  = 2'd2
  } field_e;

  // Edit-field order seen by the user: sec -> min -> hr -> sec
  function automatic field_e next_field(input field_e f);
    case (f)
      FIELD_SEC: return FIELD_MIN;
      FIELD_MIN: return FIELD_HR;
      default:   return FIELD_SEC;
    endcase
  endfunction

endpackage

// File: rtl/countdown_timer_module_if.sv
// User-button pulses in, hh:mm:ss display bus and status flags out.
interface countdown_timer_module_if;

  logic       i_set;
  logic       i_up;
  logic       i_down;
  logic       i_start;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hr;
  logic [1:0] o_field;
  logic       o_running;
  logic       o_alarm;

  modport master (
    output i_set, i_up, i_down, i_start,
    input  o_sec, o_min, o_hr, o_field, o_running, o_alarm
  );

  modport slave (
    input  i_set, i_up, i_down, i_start,
    output o_sec, o_min, o_hr, o_field, o_running, o_alarm
  );

endinterface

// File: rtl/countdown_timer_module_mod_n_updown_counter.sv
// Modulo-(MAX+1) up/down counter used for each time field. The borrow
// output is combinational so a chain of these decrements in one edge.
module mod_n_updown_counter #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_up,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carryup,
  output logic             o_borrowdown
);

  assign o_carryup    = i_up && (o_count == WIDTH'(MAX));
  assign o_borrowdown = i_down && (o_count == '0);

  // Step once per pulse, wrapping at both ends; simultaneous up and down cancel
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_up && !i_down) begin
      o_count <= (o_count == WIDTH'(MAX)) ? '0 : o_count + 1'b1;
    end else if (i_down && !i_up) begin
      o_count <= (o_count == '0) ? WIDTH'(MAX) : o_count - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_module.sv
// Countdown timer: edit hh:mm:ss in SET, count down once per second in RUN,
// freeze in PAUSE, and hold a sticky alarm in DONE once 00:00:00 is reached.
module countdown_timer_module
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC = 1000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  countdown_timer_module_if.slave   bus
);

  localparam int PW = $clog2(CLK_PER_SEC);

  timer_state_e  state;
  field_e        field;
  logic [PW-1:0] presc;
  logic          running;
  logic          alarm;

  logic [5:0] sec_count;
  logic [5:0] min_count;
  logic [4:0] hr_count;

  logic tick;
  logic edit_up;
  logic edit_down;
  logic sec_up, sec_down, min_up, min_down, hr_up, hr_down;
  logic sec_carry, min_carry, hr_carry;
  logic sec_borrow, min_borrow, hr_borrow;
  logic time_zero;
  logic last_second;
  logic unused_flags;

  assign tick        = (state == RUN) && (presc == PW'(CLK_PER_SEC - 1));
  assign time_zero   = (sec_count == 6'd0) && (min_count == 6'd0) && (hr_count == 5'd0);
  assign last_second = (sec_count == 6'd1) && (min_count == 6'd0) && (hr_count == 5'd0);

  // Field edits only happen in SET when neither start nor set claims the cycle
  always_comb begin
    edit_up   = 1'b0;
    edit_down = 1'b0;
    if (state == SET && !bus.i_start && !bus.i_set && (bus.i_up != bus.i_down)) begin
      edit_up   = bus.i_up;
      edit_down = bus.i_down;
    end
  end

  assign sec_up   = edit_up && (field == FIELD_SEC);
  assign min_up   = edit_up && (field == FIELD_MIN);
  assign hr_up    = edit_up && (field == FIELD_HR);
  assign sec_down = tick || (edit_down && (field == FIELD_SEC));
  assign min_down = (state == RUN) ? sec_borrow : (edit_down && (field == FIELD_MIN));
  assign hr_down  = (state == RUN) ? min_borrow : (edit_down && (field == FIELD_HR));

  assign unused_flags = sec_carry ^ min_carry ^ hr_carry ^ hr_borrow;

  mod_n_updown_counter #(.MAX(SEC_MAX), .WIDTH(6)) u_sec (
    .i_clk(i_clk), .i_rst(i_rst), .i_up(sec_up), .i_down(sec_down),
    .o_count(sec_count), .o_carryup(sec_carry), .o_borrowdown(sec_borrow)
  );

  mod_n_updown_counter #(.MAX(MIN_MAX), .WIDTH(6)) u_min (
    .i_clk(i_clk), .i_rst(i_rst), .i_up(min_up), .i_down(min_down),
    .o_count(min_count), .o_carryup(min_carry), .o_borrowdown(min_borrow)
  );

  mod_n_updown_counter #(.MAX(HR_MAX), .WIDTH(5)) u_hr (
    .i_clk(i_clk), .i_rst(i_rst), .i_up(hr_up), .i_down(hr_down),
    .o_count(hr_count), .o_carryup(hr_carry), .o_borrowdown(hr_borrow)
  );

  // Mode FSM with prescaler and field select; reaching zero outranks a pause request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= SET;
      field   <= FIELD_SEC;
      presc   <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      case (state)
        SET: begin
          if (bus.i_start) begin
            if (!time_zero) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end else if (bus.i_set) begin
            field <= next_field(field);
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick && last_second) begin
            state   <= DONE;
            running <= 1'b0;
            alarm   <= 1'b1;
          end else if (bus.i_start) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.i_start) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (bus.i_set) begin
            state <= SET;
            field <= FIELD_SEC;
            presc <= '0;
          end
        end
        DONE: begin
          if (bus.i_start || bus.i_set) begin
            state <= SET;
            field <= FIELD_SEC;
            alarm <= 1'b0;
          end
        end
        default: state <= SET;
      endcase
    end
  end

  assign bus.o_sec     = sec_count;
  assign bus.o_min     = min_count;
  assign bus.o_hr      = hr_count;
  assign bus.o_field   = field;
  assign bus.o_running = running;
  assign bus.o_alarm   = alarm;

endmodule
